// File: rtl/stream_uart_emitter.sv
// Byte stream -> FIFO -> 8N1/8N2 UART; optional LF after tlast bytes (STREAM_UART_EMITTER_LF_EN).
// Pop/start bit one cycle after push when idle; back-to-back frames; o_tready drops when FIFO full.
module stream_uart_emitter #(
  parameter int BAUD_DIV  = 434,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_tdata,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       o_tready,
  output logic                       o_uart_tx,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(BAUD_DIV - 1);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          push, pop;
  logic [8:0]    rd_dat;
`ifdef STREAM_UART_EMITTER_LF_EN
  logic          lf_q, lf_d;
`else
  logic          unused_tlast;
  assign unused_tlast = rd_dat[8];
`endif

  assign o_tready  = (count_q != FULL);
  assign o_level   = count_q;
  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != S_IDLE) || (count_q != '0);
  assign push      = i_tvalid && o_tready;
  assign rd_dat    = mem[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= {i_tlast, i_tdata};
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef STREAM_UART_EMITTER_LF_EN
    lf_d    = lf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_STOP: begin
        // bit_q doubles as the stop-bit counter so 8N2 needs no extra state
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else if (bit_q != STOP_LAST) begin
          bit_d  = bit_q + 3'd1;
          baud_d = BAUD_MAX;
`ifdef STREAM_UART_EMITTER_LF_EN
        end else if (lf_q) begin
          lf_d    = 1'b0;
          shreg_d = 8'h0A;
          state_d = S_START;
          baud_d  = BAUD_MAX;
          tx_d    = 1'b0;
`endif
        end else if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shreg_d = rd_dat[7:0];
      state_d = S_START;
      baud_d  = BAUD_MAX;
      tx_d    = 1'b0;
`ifdef STREAM_UART_EMITTER_LF_EN
      lf_d    = rd_dat[8];
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef STREAM_UART_EMITTER_LF_EN
      lf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef STREAM_UART_EMITTER_LF_EN
      lf_q     <= lf_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_uart_emitter.sv
// Bench for stream_uart_emitter: UART line decoders feed a byte scoreboard; timing checked per cycle.
module tb_stream_uart_emitter;

  localparam int BD = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata0 = '0, tdata1 = '0;
  logic       tlast0 = 1'b0, tlast1 = 1'b0;
  logic       tvalid0 = 1'b0, tvalid1 = 1'b0;
  logic       tready0, tready1, tx0, tx1, busy0, busy1;
  logic [2:0] level0, level1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int epoch = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int st0[$];
  int st1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_uart_emitter #(.BAUD_DIV(BD), .DEPTH(DP), .STOP_BITS(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata0), .i_tlast(tlast0), .i_tvalid(tvalid0),
    .o_tready(tready0), .o_uart_tx(tx0), .o_busy(busy0), .o_level(level0));

  stream_uart_emitter #(.BAUD_DIV(BD), .DEPTH(DP), .STOP_BITS(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata1), .i_tlast(tlast1), .i_tvalid(tvalid1),
    .o_tready(tready1), .o_uart_tx(tx1), .o_busy(busy1), .o_level(level1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic line(input int id);
    return (id == 0) ? tx0 : tx1;
  endfunction

  // Frame decoder: samples each bit in its second cycle, abandons frames cut by reset.
  task automatic uart_mon(input int id);
    int sb;
    int ep;
    logic [7:0] b;
    logic       stop;
    logic [7:0] e;
    sb = (id == 0) ? 1 : 2;
    forever begin
      while (line(id) !== 1'b0 || !rst_n) @(negedge clk);
      ep = epoch;
      if (id == 0) st0.push_back(cyc); else st1.push_back(cyc);
      repeat (BD + 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = line(id);
        repeat (BD) @(negedge clk);
      end
      stop = line(id);
      if (epoch == ep) begin
        chk($sformatf("stop_bit%0d", id), {31'd0, stop}, 32'd1);
        if (id == 0 && exp0.size() > 0) begin
          e = exp0.pop_front();
          chk("byte0", {24'd0, b}, {24'd0, e});
        end else if (id == 1 && exp1.size() > 0) begin
          e = exp1.pop_front();
          chk("byte1", {24'd0, b}, {24'd0, e});
        end else begin
          chk($sformatf("extra_byte%0d", id), {24'd0, b}, 32'hFFFF_FFFF);
        end
      end
      repeat (sb * BD - 1) @(negedge clk);
    end
  endtask

  initial uart_mon(0);
  initial uart_mon(1);

  task automatic push(input int id, input logic [7:0] d, input logic l);
    @(negedge clk);
    if (id == 0) begin
      tvalid0 = 1'b1; tdata0 = d; tlast0 = l;
      chk("push_rdy0", {31'd0, tready0}, 32'd1);
      exp0.push_back(d);
`ifdef STREAM_UART_EMITTER_LF_EN
      if (l) exp0.push_back(8'h0A);
`endif
    end else begin
      tvalid1 = 1'b1; tdata1 = d; tlast1 = l;
      chk("push_rdy1", {31'd0, tready1}, 32'd1);
      exp1.push_back(d);
    end
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    tvalid0 = 1'b0; tlast0 = 1'b0;
    tvalid1 = 1'b0; tlast1 = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (n < 2000 && ((id == 0) ? (busy0 || exp0.size() != 0) : (busy1 || exp1.size() != 0))) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_timeout%0d", id), {31'd0, n < 2000}, 32'd1);
    repeat (BD * 3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] bytes6 [6];
    int acc, first_low, gap;
    int acc_edge [6];
    logic expb;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_tready", {31'd0, tready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_level", {29'd0, level0}, 32'd0);
    chk("rst_tx2", {31'd0, tx1}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 0x55: exact line waveform and busy window
    pat = 8'h55;
    push(0, pat, 1'b0);
    idle_bus();
    chk("t1_level_c0", {29'd0, level0}, 32'd1);
    chk("t1_tx_c0", {31'd0, tx0}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 4) expb = 1'b0;
      else if (k <= 36) expb = pat[(k - 5) / 4];
      else expb = 1'b1;
      chk($sformatf("t1_tx_c%0d", k), {31'd0, tx0}, {31'd0, expb});
      chk($sformatf("t1_busy_c%0d", k), {31'd0, busy0}, 32'd1);
    end
    @(negedge clk);
    chk("t1_busy_end", {31'd0, busy0}, 32'd0);
    drain(0);

    // continuous valid with six bytes: fill depth and re-open timing
    bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    acc = 0;
    first_low = -1;
    for (int i = 0; i < 6; i++) acc_edge[i] = -1;
    @(negedge clk);
    tvalid0 = 1'b1;
    for (int c = 0; c < 200 && acc < 6; c++) begin
      tdata0 = bytes6[acc];
      if (tready0) begin
        exp0.push_back(bytes6[acc]);
        acc_edge[acc] = c;
        acc++;
      end else if (first_low < 0) begin
        first_low = c;
      end
      @(negedge clk);
    end
    tvalid0 = 1'b0;
    chk("t2_accepted", acc, 6);
    chk("t2_fifth_edge", acc_edge[4], 4);
    chk("t2_tready_low", first_low, 5);
    chk("t2_sixth_edge", acc_edge[5], 10 * BD + 2);
    drain(0);

    // 0x00 then 0xFF back-to-back: no idle gap between frames
    st0.delete();
    push(0, 8'h00, 1'b0);
    push(0, 8'hFF, 1'b0);
    idle_bus();
    drain(0);
    gap = (st0.size() >= 2) ? st0[1] - st0[0] : -1;
    chk("t3_starts", st0.size(), 2);
    chk("t3_gap", gap, 10 * BD);

    // tlast handling: LF inserted only when the feature is built in
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b0);
    idle_bus();
    drain(0);

    // reset during data bit 3 of 0x00 with two bytes queued
    push(0, 8'h00, 1'b0);
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    idle_bus();
    chk("t5_level_q", {29'd0, level0}, 32'd2);
    repeat (16) @(negedge clk);
    chk("t5_tx_bit3", {31'd0, tx0}, 32'd0);
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    epoch++;
    #1;
    chk("t5_tx_async", {31'd0, tx0}, 32'd1);
    chk("t5_level_async", {29'd0, level0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_level_rel", {29'd0, level0}, 32'd0);
    chk("t5_tready_rel", {31'd0, tready0}, 32'd1);
    chk("t5_busy_rel", {31'd0, busy0}, 32'd0);
    repeat (60) @(negedge clk);
    push(0, 8'hA5, 1'b0);
    idle_bus();
    drain(0);

    // two stop bits: 8-cycle stop, next start at cycle 45
    st1.delete();
    push(1, 8'hFF, 1'b0);
    push(1, 8'h00, 1'b0);
    idle_bus();
    for (int k = 2; k <= 45; k++) begin
      @(negedge clk);
      if (k >= 37 && k <= 44) chk($sformatf("t6_stop_c%0d", k), {31'd0, tx1}, 32'd1);
      if (k == 45) chk("t6_next_start", {31'd0, tx1}, 32'd0);
    end
    drain(1);
    gap = (st1.size() >= 2) ? st1[1] - st1[0] : -1;
    chk("t6_gap", gap, 11 * BD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
